id_fwd_hazard_unit: RTL and testbench
=====================================

Name: id_fwd_hazard_unit

Overview:
Parametrised operand-forwarding, hazard-detection and ID/EX pipeline-register block for the decode stage. It generalises fixed E/M/W forwarding to NUM_FWD downstream sources with per-source data-valid, so multi-cycle results (loads, M-extension mul/div, F-extension) stall correctly. It adds a valid/ready handshake towards EX, a flush input and a saturating stall-cycle counter. It sits between the control unit/register file and the execution stage.

Parameters:
DATA_WIDTH, 32, operand width
REG_ADDR_WIDTH, 5, register address width
NUM_FWD, 3, number of forwarding sources; slot 0 is youngest (EX), slot NUM_FWD-1 is oldest (WB)
CNT_WIDTH, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
d_valid_i  in  1  decoded instruction present in ID
d_ready_o  out  1  ID instruction accepted this cycle
flush_i  in  1  kill ID instruction (taken branch/jump)
i_r1_i  in  1  instruction uses rs1
i_r2_i  in  1  instruction uses rs2
raddr_rs1_i  in  REG_ADDR_WIDTH  rs1 address
raddr_rs2_i  in  REG_ADDR_WIDTH  rs2 address
rf_rs1_i  in  DATA_WIDTH  register-file rs1 read data
rf_rs2_i  in  DATA_WIDTH  register-file rs2 read data
waddr_i  in  REG_ADDR_WIDTH  destination address
wr_i  in  1  instruction writes rd
fwd_wr_i  in  NUM_FWD  source k writes a register
fwd_waddr_i  in  NUM_FWD*REG_ADDR_WIDTH  source k dest address, bits [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
fwd_data_i  in  NUM_FWD*DATA_WIDTH  source k result, bits [k*DATA_WIDTH +: DATA_WIDTH]
fwd_dvalid_i  in  NUM_FWD  source k result available this cycle
e_ready_i  in  1  EX accepts
e_valid_o  out  1  EX register holds a valid instruction
e_rs1_o  out  DATA_WIDTH  registered resolved rs1
e_rs2_o  out  DATA_WIDTH  registered resolved rs2
e_waddr_o  out  REG_ADDR_WIDTH  registered rd
e_wr_o  out  1  registered write enable, forced 0 for bubbles
hazard_o  out  1  combinational stall request to IF/ID
stall_cnt_o  out  CNT_WIDTH  stall cycles, saturating
cnt_clr_i  in  1  synchronous counter clear

Behaviour:
- Reset, asynchronous: e_valid_o=0, e_wr_o=0, e_rs1_o=0, e_rs2_o=0, e_waddr_o=0, stall_cnt_o=0.
- Match k for rs1: fwd_wr_i[k] && waddr_k==raddr_rs1_i && raddr_rs1_i!=0. Same rule for rs2.
- Operand select: the lowest-index matching slot wins. With no match, the operand is rf_rs*_i. Address 0 always resolves to 0, whatever rf_rs*_i or the sources carry.
- Hazard: for a used operand (i_r*_i=1), stall when its winning slot has fwd_dvalid_i=0. An older valid match must never be used to bypass a younger invalid one.
- hazard_o = d_valid_i && !flush_i && (rs1 hazard || rs2 hazard).
- Advance: advance = !e_valid_o || e_ready_i.
- d_ready_o = advance && !hazard_o. It is also 1 when flush_i=1 and advance=1; the flushed instruction is consumed.
- On advance with d_valid_i && !flush_i && !hazard_o: capture resolved operands, waddr_i and wr_i; e_valid_o=1. Latency is 1 cycle.
- On advance otherwise: insert a bubble. e_valid_o=0, e_wr_o=0; e_rs1_o, e_rs2_o and e_waddr_o hold their values.
- Without advance: all E registers hold. Forwarded values are sampled only on the capture edge.
- Stall counter: increments when d_valid_i && !d_ready_o && !flush_i. This covers hazard stalls and EX back-pressure.
  - It saturates at 2^CNT_WIDTH-1.
  - cnt_clr_i has priority and sets the counter to 0 on the next edge.
- Reset mid-stall: on release, the first capture follows the rules above with no retained state.

Test Plan:
- Plain path: rs1=3, rs2=4, RF returns 0x11 and 0x22, no matches, e_ready_i=1 -> next cycle e_valid_o=1, e_rs1_o=0x11, e_rs2_o=0x22; d_ready_o=1.
- Priority: slots 0 and 2 both write x5 with dvalid=1, data 0xAAAA and 0xBBBB; rs1=5 -> e_rs1_o=0xAAAA.
- Load-use: slot 0 writes x7 with dvalid=0 for 2 cycles, then 1 with data 0x1234; slot 1 also has x7 valid with 0x9999; rs2=7, i_r2_i=1:
  - hazard_o=1 for 2 cycles, with bubbles (e_valid_o=0, e_wr_o=0);
  - then e_rs2_o=0x1234;
  - stall_cnt_o=2.
- Unused operand: same invalid match but i_r2_i=0 -> no hazard, capture next cycle.
- x0 and flush:
  - rs1=0 while slot 0 writes x0 with 0xFFFF -> e_rs1_o=0.
  - flush_i=1 with d_valid_i=1 -> d_ready_o=1, e_valid_o=0, counter unchanged.
- Back-pressure and saturation:
  - e_valid_o=1, e_ready_i=0 for 3 cycles -> E outputs hold, d_ready_o=0, counter +3.
  - CNT_WIDTH=2, 5 stall cycles -> stall_cnt_o=3.
  - Assert rst_n=0 mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_fwd_hazard_unit.sv
// Decode-stage operand forwarding across NUM_FWD downstream sources, load-use/multi-cycle
// hazard detection, and the ID/EX pipeline register with a valid/ready handshake.
module id_fwd_hazard_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_FWD        = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             d_valid_i,
  output logic                             d_ready_o,
  input  logic                             flush_i,
  input  logic                             i_r1_i,
  input  logic                             i_r2_i,
  input  logic [REG_ADDR_WIDTH-1:0]        raddr_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]        raddr_rs2_i,
  input  logic [DATA_WIDTH-1:0]            rf_rs1_i,
  input  logic [DATA_WIDTH-1:0]            rf_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0]        waddr_i,
  input  logic                             wr_i,
  input  logic [NUM_FWD-1:0]               fwd_wr_i,
  input  logic [NUM_FWD*REG_ADDR_WIDTH-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_WIDTH-1:0]    fwd_data_i,
  input  logic [NUM_FWD-1:0]               fwd_dvalid_i,
  input  logic                             e_ready_i,
  output logic                             e_valid_o,
  output logic [DATA_WIDTH-1:0]            e_rs1_o,
  output logic [DATA_WIDTH-1:0]            e_rs2_o,
  output logic [REG_ADDR_WIDTH-1:0]        e_waddr_o,
  output logic                             e_wr_o,
  output logic                             hazard_o,
  output logic [CNT_WIDTH-1:0]             stall_cnt_o,
  input  logic                             cnt_clr_i
);

  typedef struct packed {
    logic                  pend;
    logic [DATA_WIDTH-1:0] val;
  } opnd_t;

  // Scan oldest to youngest so the youngest matching slot overwrites; its dvalid alone decides
  // the stall, so an older ready copy can never mask a younger pending result.
  function automatic opnd_t resolve(
    input logic [REG_ADDR_WIDTH-1:0]         addr,
    input logic [DATA_WIDTH-1:0]             rf,
    input logic [NUM_FWD-1:0]                wr,
    input logic [NUM_FWD*REG_ADDR_WIDTH-1:0] waddr,
    input logic [NUM_FWD*DATA_WIDTH-1:0]     data,
    input logic [NUM_FWD-1:0]                dvalid
  );
    opnd_t r;
    r.pend = 1'b0;
    r.val  = rf;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (wr[k] && (waddr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == addr)) begin
        r.val  = data[k*DATA_WIDTH +: DATA_WIDTH];
        r.pend = !dvalid[k];
      end
    end
    if (addr == '0) begin
      r.val  = '0;
      r.pend = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  opnd_t                     rs1_p0, rs2_p0;
  logic                      advance, capture, stall;
  logic                      vld_p1, wr_p1;
  logic [DATA_WIDTH-1:0]     rs1_p1, rs2_p1;
  logic [REG_ADDR_WIDTH-1:0] waddr_p1;
  logic [CNT_WIDTH-1:0]      cnt;

  // ID stage: operand resolution and stall decision
  assign rs1_p0 = resolve(raddr_rs1_i, rf_rs1_i, fwd_wr_i, fwd_waddr_i, fwd_data_i, fwd_dvalid_i);
  assign rs2_p0 = resolve(raddr_rs2_i, rf_rs2_i, fwd_wr_i, fwd_waddr_i, fwd_data_i, fwd_dvalid_i);

  assign hazard_o  = d_valid_i && !flush_i &&
                     ((i_r1_i && rs1_p0.pend) || (i_r2_i && rs2_p0.pend));
  assign advance   = !vld_p1 || e_ready_i;
  assign d_ready_o = advance && !hazard_o;
  assign capture   = advance && d_valid_i && !flush_i && !hazard_o;
  assign stall     = d_valid_i && !d_ready_o && !flush_i;

  // ID/EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      wr_p1    <= 1'b0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      waddr_p1 <= '0;
    end else if (advance) begin
      vld_p1 <= capture;
      wr_p1  <= capture && wr_i;
      if (capture) begin
        rs1_p1   <= rs1_p0.val;
        rs2_p1   <= rs2_p0.val;
        waddr_p1 <= waddr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr_i) begin
      cnt <= '0;
    end else if (stall) begin
      cnt <= sat_inc(cnt);
    end
  end

  assign e_valid_o   = vld_p1;
  assign e_wr_o      = wr_p1;
  assign e_rs1_o     = rs1_p1;
  assign e_rs2_o     = rs2_p1;
  assign e_waddr_o   = waddr_p1;
  assign stall_cnt_o = cnt;

endmodule

// File: tb/tb_id_fwd_hazard_unit.sv
// Scoreboard bench for id_fwd_hazard_unit: directed scenarios then random traffic, checked
// against a transaction-level reference model; a CNT_WIDTH=2 copy exercises counter saturation.
module tb_id_fwd_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, d_valid, flush, i_r1, i_r2, wr, e_ready, cnt_clr;
  logic [AW-1:0] ra1, ra2, waddr;
  logic [DW-1:0] rf1, rf2;
  logic          f_wr[NF];
  logic [AW-1:0] f_addr[NF];
  logic [DW-1:0] f_data[NF];
  logic          f_dv[NF];

  logic [NF-1:0]    fwd_wr, fwd_dv;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_data;
  for (genvar k = 0; k < NF; k++) begin : g_pack
    assign fwd_wr[k]             = f_wr[k];
    assign fwd_dv[k]             = f_dv[k];
    assign fwd_waddr[k*AW +: AW] = f_addr[k];
    assign fwd_data[k*DW +: DW]  = f_data[k];
  end

  logic          d_ready, e_valid, e_wr, hazard;
  logic [DW-1:0] e_rs1, e_rs2;
  logic [AW-1:0] e_waddr;
  logic [15:0]   stall_cnt;
  logic          x_d_ready, x_e_valid, x_e_wr, x_hazard;
  logic [DW-1:0] x_e_rs1, x_e_rs2;
  logic [AW-1:0] x_e_waddr;
  logic [1:0]    x_stall_cnt;

  id_fwd_hazard_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_FWD(NF), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid_i(d_valid), .d_ready_o(d_ready), .flush_i(flush),
    .i_r1_i(i_r1), .i_r2_i(i_r2), .raddr_rs1_i(ra1), .raddr_rs2_i(ra2),
    .rf_rs1_i(rf1), .rf_rs2_i(rf2), .waddr_i(waddr), .wr_i(wr),
    .fwd_wr_i(fwd_wr), .fwd_waddr_i(fwd_waddr), .fwd_data_i(fwd_data), .fwd_dvalid_i(fwd_dv),
    .e_ready_i(e_ready), .e_valid_o(e_valid), .e_rs1_o(e_rs1), .e_rs2_o(e_rs2),
    .e_waddr_o(e_waddr), .e_wr_o(e_wr), .hazard_o(hazard), .stall_cnt_o(stall_cnt),
    .cnt_clr_i(cnt_clr));

  id_fwd_hazard_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_FWD(NF), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .d_valid_i(d_valid), .d_ready_o(x_d_ready), .flush_i(flush),
    .i_r1_i(i_r1), .i_r2_i(i_r2), .raddr_rs1_i(ra1), .raddr_rs2_i(ra2),
    .rf_rs1_i(rf1), .rf_rs2_i(rf2), .waddr_i(waddr), .wr_i(wr),
    .fwd_wr_i(fwd_wr), .fwd_waddr_i(fwd_waddr), .fwd_data_i(fwd_data), .fwd_dvalid_i(fwd_dv),
    .e_ready_i(e_ready), .e_valid_o(x_e_valid), .e_rs1_o(x_e_rs1), .e_rs2_o(x_e_rs2),
    .e_waddr_o(x_e_waddr), .e_wr_o(x_e_wr), .hazard_o(x_hazard), .stall_cnt_o(x_stall_cnt),
    .cnt_clr_i(cnt_clr));

  typedef struct {
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
    logic [AW-1:0] waddr;
    logic          wr;
  } txn_t;

  txn_t q[$];
  txn_t m_last;
  bit   m_evalid;
  int   m_cnt, m_cnt2;
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the youngest slot writing the address supplies the value and its readiness.
  task automatic ref_resolve(input logic [AW-1:0] a, input logic [DW-1:0] rf,
                             output logic [DW-1:0] v, output bit pend);
    v = rf;
    pend = 0;
    if (a == 0) begin
      v = 0;
      return;
    end
    for (int k = 0; k < NF; k++) begin
      if (f_wr[k] && f_addr[k] == a) begin
        v = f_data[k];
        pend = !f_dv[k];
        return;
      end
    end
  endtask

  task automatic set_idle();
    d_valid = 0; flush = 0; i_r1 = 0; i_r2 = 0; wr = 0; e_ready = 1; cnt_clr = 0;
    ra1 = 0; ra2 = 0; waddr = 0; rf1 = 0; rf2 = 0;
    for (int k = 0; k < NF; k++) begin
      f_wr[k] = 0; f_addr[k] = 0; f_data[k] = 0; f_dv[k] = 1;
    end
  endtask

  // One clock: compare combinational outputs and model state mid-cycle, then advance the model.
  task automatic step();
    logic [DW-1:0] v1, v2;
    bit p1, p2, haz, adv, rdy, cap, stl, n_evalid;
    int n_cnt, n_cnt2;
    txn_t t, n_last;
    @(negedge clk);
    ref_resolve(ra1, rf1, v1, p1);
    ref_resolve(ra2, rf2, v2, p2);
    haz = d_valid && !flush && ((i_r1 && p1) || (i_r2 && p2));
    adv = !m_evalid || e_ready;
    rdy = adv && !haz;
    cap = adv && d_valid && !flush && !haz;
    stl = d_valid && !rdy && !flush;
    chk("hazard", hazard, haz);
    chk("d_ready", d_ready, rdy);
    chk("e_valid", e_valid, m_evalid);
    chk("stall_cnt", stall_cnt, m_cnt);
    chk("stall_cnt_sat", x_stall_cnt, m_cnt2);
    t.rs1 = v1; t.rs2 = v2; t.waddr = waddr; t.wr = wr;
    if (cap) q.push_back(t);
    n_evalid = adv ? cap : m_evalid;
    n_last   = cap ? t : m_last;
    n_cnt    = cnt_clr ? 0 : (stl ? ((m_cnt < 65535) ? m_cnt + 1 : 65535) : m_cnt);
    n_cnt2   = cnt_clr ? 0 : (stl ? ((m_cnt2 < 3) ? m_cnt2 + 1 : 3) : m_cnt2);
    @(posedge clk);
    m_evalid = n_evalid; m_last = n_last; m_cnt = n_cnt; m_cnt2 = n_cnt2;
    #1;
  endtask

  task automatic model_reset();
    m_evalid = 0; m_cnt = 0; m_cnt2 = 0;
    m_last.rs1 = 0; m_last.rs2 = 0; m_last.waddr = 0; m_last.wr = 0;
    q.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_e_valid", e_valid, 0);
    chk("rst_e_wr", e_wr, 0);
    chk("rst_e_rs1", e_rs1, 0);
    chk("rst_e_rs2", e_rs2, 0);
    chk("rst_e_waddr", e_waddr, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_stall_cnt_sat", x_stall_cnt, 0);
  endtask

  // Monitor: the EX register must show the oldest unretired captured instruction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (e_valid) begin
        if (q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL ex_unexpected: e_valid=1 with no instruction outstanding (t=%0t)", $time);
        end else begin
          chk("ex_rs1", e_rs1, q[0].rs1);
          chk("ex_rs2", e_rs2, q[0].rs2);
          chk("ex_waddr", e_waddr, q[0].waddr);
          chk("ex_wr", e_wr, q[0].wr);
          if (e_ready) void'(q.pop_front());
        end
      end else begin
        chk("bubble_wr", e_wr, 0);
        chk("bubble_rs1_hold", e_rs1, m_last.rs1);
        chk("bubble_rs2_hold", e_rs2, m_last.rs2);
        chk("bubble_waddr_hold", e_waddr, m_last.waddr);
      end
    end
  end

  initial begin
    rst_n = 0;
    set_idle();
    model_reset();
    #12;
    chk_reset_outputs();
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // Plain register-file path
    d_valid = 1; i_r1 = 1; i_r2 = 1; ra1 = 3; ra2 = 4; rf1 = 32'h11; rf2 = 32'h22;
    waddr = 9; wr = 1;
    step();
    set_idle(); step();

    // Youngest slot wins
    d_valid = 1; i_r1 = 1; ra1 = 5; rf1 = 32'h77; waddr = 6; wr = 1;
    f_wr[0] = 1; f_addr[0] = 5; f_data[0] = 32'hAAAA;
    f_wr[2] = 1; f_addr[2] = 5; f_data[2] = 32'hBBBB;
    step();
    set_idle(); cnt_clr = 1; step();

    // Load-use: pending young result must not be bypassed by an older ready one
    d_valid = 1; i_r2 = 1; ra2 = 7; rf2 = 32'h5555; waddr = 8; wr = 1;
    f_wr[0] = 1; f_addr[0] = 7; f_dv[0] = 0;
    f_wr[1] = 1; f_addr[1] = 7; f_data[1] = 32'h9999;
    step(); step();
    f_dv[0] = 1; f_data[0] = 32'h1234;
    step();
    // Same pending match but rs2 unused
    f_dv[0] = 0; i_r2 = 0;
    step();
    set_idle(); step();

    // x0 always reads zero
    d_valid = 1; i_r1 = 1; ra1 = 0; rf1 = 32'h55; wr = 1; waddr = 1;
    f_wr[0] = 1; f_addr[0] = 0; f_data[0] = 32'hFFFF; f_dv[0] = 0;
    step();
    // Flush consumes the instruction, even with a hazard present
    set_idle(); d_valid = 1; flush = 1; i_r1 = 1; ra1 = 2;
    f_wr[0] = 1; f_addr[0] = 2; f_dv[0] = 0;
    step();
    set_idle(); step();

    // Back-pressure long enough to saturate the 2-bit counter, then reset mid-stall
    d_valid = 1; i_r1 = 1; ra1 = 10; rf1 = 32'hCAFE; waddr = 3; wr = 1;
    step();
    e_ready = 0; ra1 = 11; rf1 = 32'hBEEF;
    repeat (5) step();
    #2 rst_n = 0;
    #1 chk_reset_outputs();
    model_reset();
    set_idle();
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    d_valid = 1; i_r1 = 1; i_r2 = 1; ra1 = 12; ra2 = 13; rf1 = 32'h1; rf2 = 32'h2;
    waddr = 4; wr = 1;
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      d_valid = ($urandom_range(0, 9) < 8);
      flush   = ($urandom_range(0, 9) == 0);
      e_ready = ($urandom_range(0, 9) < 7);
      cnt_clr = ($urandom_range(0, 49) == 0);
      i_r1 = 1'($urandom); i_r2 = 1'($urandom); wr = 1'($urandom);
      ra1 = AW'($urandom_range(0, 7)); ra2 = AW'($urandom_range(0, 7));
      waddr = AW'($urandom_range(0, 31));
      rf1 = $urandom; rf2 = $urandom;
      for (int k = 0; k < NF; k++) begin
        f_wr[k] = 1'($urandom); f_addr[k] = AW'($urandom_range(0, 7));
        f_data[k] = $urandom; f_dv[k] = ($urandom_range(0, 9) < 7);
      end
      step();
    end

    set_idle();
    repeat (3) step();
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
